// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data-memory responder: size codes, FSM states,
// byte-lane mask and alignment checks (also used by the lane aligner).
package data_ram_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  function automatic logic [7:0] size_to_bytemask(input size_e size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      SZ_D:    base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << offset;
  endfunction

  function automatic logic [63:0] size_to_datamask(input size_e size);
    logic [63:0] m;
    case (size)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      SZ_D:    m = 64'hFFFF_FFFF_FFFF_FFFF;
      default: m = 64'h0000_0000_0000_0000;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input size_e size, input logic [2:0] offset);
    logic r;
    case (size)
      SZ_B:    r = 1'b0;
      SZ_H:    r = offset[0];
      SZ_W:    r = |offset[1:0];
      SZ_D:    r = |offset;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_ram_if.sv
// Core-to-data-memory request/response bundle; the core drives through master,
// the memory responds through slave.
interface data_ram_if;
  logic        req;
  logic        rw;
  logic [63:0] addr;
  logic [1:0]  size;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        valid;
  logic        err;
  logic        busy;

  modport master (
    output req, rw, addr, size, wdata,
    input  rdata, valid, err, busy
  );

  modport slave (
    input  req, rw, addr, size, wdata,
    output rdata, valid, err, busy
  );
endinterface

// File: rtl/data_ram_lane_align.sv
// Combinational byte-lane aligner: places right-justified store data into its lanes
// and extracts right-justified, zero-extended load data from a 64-bit word.
module data_ram_lane_align
  import data_ram_pkg::*;
(
  input  size_e       size,
  input  logic [2:0]  offset,
  input  logic [63:0] wdata,
  input  logic [63:0] rword,
  output logic [63:0] wlanes,
  output logic [7:0]  wbe,
  output logic [63:0] rdata
);

  logic [5:0] shamt_s;

  assign shamt_s = {offset, 3'b000};
  assign wlanes  = wdata << shamt_s;
  assign wbe     = size_to_bytemask(size, offset);
  assign rdata   = (rword >> shamt_s) & size_to_datamask(size);

endmodule

// File: rtl/data_ram.sv
// Single-outstanding data-memory responder with byte/half/word/dword access and a
// one-cycle response pulse. Define DATA_RAM_WAIT_EN to insert WAIT_CYCLES extra cycles.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  data_ram_if.slave  bus
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("data_ram: WAIT_CYCLES must be in 1..15");
  end

  logic [63:0] mem_q [WORDS];

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [63:0] rdata_q, rdata_d;
`ifdef DATA_RAM_WAIT_EN
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
`endif

  size_e                 size_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  accept_s;
  logic                  oor_s;
  logic                  req_err_s;
  logic                  we_s;
  logic [63:0]           rword_s;
  logic [63:0]           wlanes_s;
  logic [7:0]            wbe_s;
  logic [63:0]           load_s;
  logic [63:0]           req_data_s;

  assign size_s     = size_e'(bus.size);
  assign idx_s      = bus.addr[DEPTH_LOG2+2:3];
  assign accept_s   = (state_q == S_IDLE) && bus.req;
  assign oor_s      = |bus.addr[63:DEPTH_LOG2+3];
  assign req_err_s  = oor_s | misaligned(size_s, bus.addr[2:0]);
  assign rword_s    = mem_q[idx_s];
  assign we_s       = accept_s && bus.rw && !req_err_s && !rst;
  assign req_data_s = (!bus.rw && !req_err_s) ? load_s : 64'd0;

  data_ram_lane_align u_align (
    .size   (size_s),
    .offset (bus.addr[2:0]),
    .wdata  (bus.wdata),
    .rword  (rword_s),
    .wlanes (wlanes_s),
    .wbe    (wbe_s),
    .rdata  (load_s)
  );

  // Stores commit on the accept edge; the array itself is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we_s && wbe_s[i]) begin
        mem_q[idx_s][8*i +: 8] <= wlanes_s[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = 64'd0;
`ifdef DATA_RAM_WAIT_EN
    wait_cnt_d  = wait_cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
`ifdef DATA_RAM_WAIT_EN
          state_d     = S_WAIT;
          wait_cnt_d  = 4'(WAIT_CYCLES - 1);
          resp_data_d = req_data_s;
          resp_err_d  = req_err_s;
`else
          state_d = S_RESP;
          valid_d = 1'b1;
          err_d   = req_err_s;
          rdata_d = req_data_s;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
`ifdef DATA_RAM_WAIT_EN
        if (wait_cnt_q == 4'd0) begin
          state_d = S_RESP;
          valid_d = 1'b1;
          err_d   = resp_err_q;
          rdata_d = resp_data_q;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Outputs are registered alongside the state so they line up with RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 64'd0;
`ifdef DATA_RAM_WAIT_EN
      wait_cnt_q  <= 4'd0;
      resp_data_q <= 64'd0;
      resp_err_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
`ifdef DATA_RAM_WAIT_EN
      wait_cnt_q  <= wait_cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
`endif
    end
  end

  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed cases plus random traffic compared
// against a byte-addressed reference memory.
module tb_data_ram;

`ifdef DATA_RAM_WAIT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int MEM_BYTES = 8192;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_ram_if bus ();

  data_ram dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ref_mem [MEM_BYTES];
  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: byte-granular memory, error if not size-aligned or beyond the array.
  task automatic model_access(input logic rw, input logic [63:0] addr, input logic [1:0] size,
                              input logic [63:0] wdata, output logic err, output logic [63:0] data);
    int n;
    n = 1 << size;
    err = ((addr % 64'(n)) != 64'd0) || (addr >= 64'(MEM_BYTES));
    data = 64'd0;
    if (!err) begin
      for (int b = 0; b < n; b++) begin
        if (rw) ref_mem[int'(addr) + b] = wdata[8*b +: 8];
        else    data[8*b +: 8] = ref_mem[int'(addr) + b];
      end
    end
  endtask

  task automatic do_req(input logic rw, input logic [63:0] addr, input logic [1:0] size,
                        input logic [63:0] wdata);
    logic        exp_err;
    logic [63:0] exp_data;
    int          n;
    model_access(rw, addr, size, wdata, exp_err, exp_data);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.rw    = rw;
    bus.addr  = addr;
    bus.size  = size;
    bus.wdata = wdata;
    @(negedge clk);
    bus.req = 1'b0;
    n = 1;
    while (bus.valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("latency", 64'(n), 64'(LAT));
    check_val("valid", {63'd0, bus.valid}, 64'd1);
    check_val("err", {63'd0, bus.err}, {63'd0, exp_err});
    check_val("rdata", bus.rdata, exp_data);
    check_val("busy_resp", {63'd0, bus.busy}, 64'd1);
    @(negedge clk);
    check_val("valid_drop", {63'd0, bus.valid}, 64'd0);
    check_val("busy_idle", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] m;
    logic [1:0]  sz;
    logic        e;
    logic [63:0] d;
    int          r;
    int          nvalid;

    rst       = 1'b1;
    bus.req   = 1'b0;
    bus.rw    = 1'b0;
    bus.addr  = 64'd0;
    bus.size  = 2'b00;
    bus.wdata = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("rst_valid", {63'd0, bus.valid}, 64'd0);
    check_val("rst_err", {63'd0, bus.err}, 64'd0);
    check_val("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_val("rst_rdata", bus.rdata, 64'd0);

    for (int i = 0; i < MEM_BYTES / 8; i++) do_req(1'b1, 64'(i * 8), 2'b11, 64'd0);

    do_req(1'b1, 64'h40, 2'b11, 64'h1122_3344_5566_7788);
    do_req(1'b0, 64'h40, 2'b11, 64'd0);
    do_req(1'b1, 64'h43, 2'b00, 64'h0000_0000_0000_00AB);
    do_req(1'b0, 64'h40, 2'b11, 64'd0);
    check_val("byte_merge", bus.rdata, 64'd0);
    do_req(1'b0, 64'h42, 2'b01, 64'd0);
    do_req(1'b0, 64'h42, 2'b10, 64'd0);
    do_req(1'b1, 64'h42, 2'b10, 64'h0000_0000_FFFF_FFFF);
    do_req(1'b0, 64'h40, 2'b11, 64'd0);
    do_req(1'b0, 64'h2000, 2'b11, 64'd0);
    do_req(1'b1, 64'h1FF8, 2'b11, 64'hDEAD_BEEF_0BAD_F00D);
    do_req(1'b0, 64'h1FF8, 2'b11, 64'd0);
    do_req(1'b0, 64'h8000_0000_0000_0040, 2'b11, 64'd0);
    do_req(1'b0, 64'h45, 2'b00, 64'd0);

    // req held high: one accept per LAT+1 cycles, exactly one valid per accept.
    model_access(1'b0, 64'h40, 2'b11, 64'd0, e, d);
    @(negedge clk);
    bus.req  = 1'b1;
    bus.rw   = 1'b0;
    bus.addr = 64'h40;
    bus.size = 2'b11;
    nvalid = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_val("hold_valid", {63'd0, bus.valid}, {63'd0, (k % (LAT + 1)) == LAT});
      check_val("hold_busy", {63'd0, bus.busy}, {63'd0, (k % (LAT + 1)) != 0});
      if (bus.valid === 1'b1) begin
        nvalid++;
        check_val("hold_rdata", bus.rdata, d);
      end
    end
    bus.req = 1'b0;
    check_val("hold_count", 64'(nvalid), 64'(12 / (LAT + 1)));
    @(negedge clk);
    @(negedge clk);

    // Reset right after an accept aborts the response.
    bus.req = 1'b1;
    bus.rw  = 1'b0;
    bus.addr = 64'h40;
    @(negedge clk);
    bus.req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_valid", {63'd0, bus.valid}, 64'd0);
    check_val("abort_busy", {63'd0, bus.busy}, 64'd0);
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) nvalid++;
    end
    check_val("abort_no_resp", 64'(nvalid), 64'd0);
    do_req(1'b0, 64'h40, 2'b11, 64'd0);

    for (int t = 0; t < 400; t++) begin
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      if (r == 0)      a = 64'h2000 + 64'($urandom_range(0, 255));
      else if (r == 1) a = {$urandom, $urandom} | 64'h0100_0000_0000_0000;
      else             a = 64'($urandom_range(0, MEM_BYTES - 1));
      if (r < 8) begin
        m = 64'(1 << sz) - 64'd1;
        a = a & ~m;
      end
      do_req(1'($urandom_range(0, 1)), a, sz, {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
